// File: rtl/submuland_pkg.sv
// Shared definitions for the submuland pipeline.
//   WIDTH_DEFAULT : default operand/result width in bits.
//   STAGES        : number of pipeline slots between input and output.
//   word_t        : one operand or result word at the default width.
//   stage_t       : view of one pipeline slot {valid, data, b, c}.
package submuland_pkg;

  localparam int WIDTH_DEFAULT = 9;
  localparam int STAGES        = 3;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t data;
    word_t b;
    word_t c;
  } stage_t;

endpackage

// File: rtl/submuland_stage.sv
// One valid/data slot of the submuland pipeline.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears valid and data)
//   load       : upstream hands a payload to this slot this cycle
//   adv        : this slot hands its payload downstream this cycle
//   din        : upstream payload, W bits
//   valid      : slot holds a live payload
//   data       : registered payload, held while the slot neither loads nor advances
module submuland_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  // load wins over adv: advancing and refilling in the same cycle keeps the
  // slot occupied, which is what lets a full pipeline stream without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (adv) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/submuland_3_stage_unsigned_9_bit.sv
// Streaming 3-stage unsigned pipeline: out = ((d - a) * b) & c, modulo 2^WIDTH.
// Configuration macro: SUBMULAND_SAT_SUB_EN selects a saturating subtract
// (d >= a ? d - a : 0) in stage 0; otherwise the subtract wraps.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake for tuple {a, b, c, d}
//   a, b, c, d          : subtrahend, multiplicand, AND mask, minuend
//   out_valid/out_ready : output handshake for out
//   out                 : result
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until accepted, and ready may
// depend combinationally on the downstream ready (in_ready follows out_ready).
module submuland_3_stage_unsigned_9_bit
  import submuland_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
);

  localparam int P0 = 3 * WIDTH;  // {diff, b, c}
  localparam int P1 = 2 * WIDTH;  // {prod, c}
  localparam int P2 = WIDTH;      // result

  logic          v0, v1, v2;
  logic          adv0, adv1, adv2, accept;
  logic [P0-1:0] p0_in, p0;
  logic [P1-1:0] p1_in, p1;
  logic [P2-1:0] p2_in, p2;
  logic [WIDTH-1:0] diff, s0_diff, s0_b, s0_c, prod, s1_prod, s1_c;

  // Each stage moves on when its successor is empty or itself moving, so an
  // empty slot anywhere is filled even while the output is stalled.
  assign adv2     = v2 & out_ready;
  assign adv1     = v1 & (~v2 | adv2);
  assign adv0     = v0 & (~v1 | adv1);
  assign in_ready = ~v0 | adv0;
  assign accept   = in_valid & in_ready;

  // Stage 0 arithmetic on the incoming tuple.
`ifdef SUBMULAND_SAT_SUB_EN
  assign diff = (d >= a) ? (d - a) : '0;
`else
  assign diff = d - a;
`endif
  assign p0_in = {diff, b, c};

  submuland_stage #(.W(P0)) u_stage0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .adv   (adv0),
    .din   (p0_in),
    .valid (v0),
    .data  (p0)
  );

  assign s0_diff = p0[P0-1:2*WIDTH];
  assign s0_b    = p0[2*WIDTH-1:WIDTH];
  assign s0_c    = p0[WIDTH-1:0];

  // Only the low WIDTH bits of the 2*WIDTH product survive; evaluating the
  // multiply at WIDTH bits yields exactly those bits.
  assign prod  = WIDTH'(s0_diff * s0_b);
  assign p1_in = {prod, s0_c};

  submuland_stage #(.W(P1)) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (adv0),
    .adv   (adv1),
    .din   (p1_in),
    .valid (v1),
    .data  (p1)
  );

  assign s1_prod = p1[P1-1:WIDTH];
  assign s1_c    = p1[WIDTH-1:0];
  assign p2_in   = s1_prod & s1_c;

  submuland_stage #(.W(P2)) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (adv1),
    .adv   (adv2),
    .din   (p2_in),
    .valid (v2),
    .data  (p2)
  );

  assign out_valid = v2;
  assign out       = p2;

endmodule
